pooling_output_serializer: RTL

- Downstream neighbour of the pooling layer top.
- Captures each pooled row (OUTPUT_SIZE floats, packed) on a valid strobe and buffers rows in a small FIFO.
- Serializes rows element by element onto a valid/ready stream toward the feature-map writer and the next-layer input.
- Tags end-of-row and end-of-map, and flags overflow because the pooling stage cannot be stalled.

---
 rtl/pooling_output_serializer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pooling_output_serializer.sv
// ---------------------------------------------------------------------------
// pooling_output_serializer
// Captures pooled rows (OUTPUT_SIZE packed floats) on in_valid into a small
// row FIFO and serializes them element by element onto a valid/ready stream.
// Each element is tagged with end-of-row and end-of-map flags. The pooling
// stage cannot be stalled, so a row arriving into a full FIFO is dropped and
// the sticky overflow flag is raised.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   in_valid     one-cycle strobe, data_in holds a complete row
//   data_in      packed row, element 0 in the top DATA_WIDTH slice
//   out_valid    out_data valid
//   out_ready    downstream accepts on out_valid && out_ready
//   out_data     serialized element
//   out_last_row out_data is the last element of a row
//   out_last_map out_data is the last element of the last row of a map
//   fifo_level   rows held in the FIFO (excluding the row in the shifter)
//   overflow     sticky, a row was dropped
//
// Optional build macro: POOL_OUT_RELU_EN -- when defined, any element with
// its sign bit set is replaced by zero as the row enters the shift register.
// ---------------------------------------------------------------------------
module pooling_output_serializer #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned OUTPUT_SIZE  = 3,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned ROWS_PER_MAP = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [OUTPUT_SIZE*DATA_WIDTH-1:0] data_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_last_row,
    output logic                              out_last_map,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic                              overflow
);

    localparam int unsigned ROW_W  = OUTPUT_SIZE * DATA_WIDTH;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned CNT_W  = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int unsigned ROWC_W = (ROWS_PER_MAP > 1) ? $clog2(ROWS_PER_MAP) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t             state;
    state_t             next_state;

    logic [ROW_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ROW_W-1:0]   head_row;
    logic [ROW_W-1:0]   load_row;
    logic [ROW_W-1:0]   shreg;
    logic [CNT_W-1:0]   elem_cnt;
    logic [CNT_W-1:0]   next_cnt;
    logic [ROWC_W-1:0]  row_cnt;

    logic               fifo_empty;
    logic               fifo_full;
    logic               handshake;
    logic               last_elem;
    logic               map_end_row;
    logic               pop;
    logic               push;
    logic               advance;
    logic               row_done;

    // Status decodes
    assign fifo_empty  = (fifo_level == '0);
    assign fifo_full   = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign handshake   = out_valid && out_ready;
    assign last_elem   = (elem_cnt == CNT_W'(OUTPUT_SIZE - 1));
    assign next_cnt    = elem_cnt + CNT_W'(1);
    assign map_end_row = (row_cnt == ROWC_W'(ROWS_PER_MAP - 1));
    assign head_row    = mem[rd_ptr];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!fifo_empty) next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (handshake && last_elem) next_state = fifo_empty ? IDLE : LOAD;
            default: next_state = IDLE;
        endcase
    end

    // Control decodes; a pop in the same cycle frees the slot for a write
    always_comb begin
        pop      = (state == LOAD);
        push     = in_valid && (!fifo_full || pop);
        advance  = (state == SHIFT) && handshake && !last_elem;
        row_done = (state == SHIFT) && handshake && last_elem;
    end

    // Row as it enters the shift register
    always_comb begin
        load_row = head_row;
`ifdef POOL_OUT_RELU_EN
        for (int i = 0; i < int'(OUTPUT_SIZE); i++) begin
            if (head_row[i*DATA_WIDTH + DATA_WIDTH - 1]) begin
                load_row[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
`endif
    end

    // Row storage; contents need no reset, pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // FIFO bookkeeping, shifter and tagged output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            overflow     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last_row <= 1'b0;
            out_last_map <= 1'b0;
            shreg        <= '0;
            elem_cnt     <= '0;
            row_cnt      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);
            if (in_valid && !push) overflow <= 1'b1;

            out_valid <= (next_state == SHIFT);

            if (pop) begin
                out_data     <= load_row[ROW_W-1 -: DATA_WIDTH];
                shreg        <= load_row << DATA_WIDTH;
                elem_cnt     <= '0;
                out_last_row <= (OUTPUT_SIZE == 1);
                out_last_map <= (OUTPUT_SIZE == 1) && map_end_row;
            end else if (advance) begin
                out_data     <= shreg[ROW_W-1 -: DATA_WIDTH];
                shreg        <= shreg << DATA_WIDTH;
                elem_cnt     <= next_cnt;
                out_last_row <= (next_cnt == CNT_W'(OUTPUT_SIZE - 1));
                out_last_map <= (next_cnt == CNT_W'(OUTPUT_SIZE - 1)) && map_end_row;
            end else if (row_done) begin
                out_last_row <= 1'b0;
                out_last_map <= 1'b0;
            end

            if (row_done) begin
                row_cnt <= map_end_row ? '0 : row_cnt + ROWC_W'(1);
            end
        end
    end

endmodule
